// File: rtl/session_lookup_filter.sv
// session_lookup_filter: issues a lookup per header, holds metadata in order and joins it with the
// in-order lookup result; hits are forwarded with their connection ID, misses are dropped and counted.
module session_lookup_filter #(
  parameter int KEY_WIDTH      = 32,
  parameter int RESP_WIDTH     = 18,
  parameter int META_WIDTH     = 64,
  parameter int FIFO_DEPTH     = 8,
  parameter int LOOKUP_LATENCY = 2,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_hdr_valid,
  input  logic [KEY_WIDTH-1:0]  s_hdr_key,
  input  logic [META_WIDTH-1:0] s_hdr_meta,
  output logic                  s_hdr_ready,
  output logic                  lk_req_valid,
  output logic [KEY_WIDTH-1:0]  lk_req_key,
  input  logic                  lk_req_ready,
  input  logic                  lk_resp_valid,
  input  logic                  lk_resp_hit,
  input  logic [RESP_WIDTH-1:0] lk_resp_id,
  output logic                  m_pkt_valid,
  output logic [META_WIDTH-1:0] m_pkt_meta,
  output logic [RESP_WIDTH-1:0] m_pkt_conn_id,
  input  logic                  m_pkt_ready,
  input  logic                  clear_counters,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count,
  output logic                  resp_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(LOOKUP_LATENCY + 1);
  logic [META_WIDTH-1:0] meta_mem [FIFO_DEPTH];
  logic [RESP_WIDTH:0]   res_mem  [FIFO_DEPTH];
  logic [AW-1:0] meta_wr, meta_rd, res_wr, res_rd;
  logic [CW-1:0] meta_count, result_count;
  logic [LW-1:0] flush_cnt;
  logic flushing, credit_ok, accept, resp_push, resp_orphan, retire, head_hit;
  assign flushing    = flush_cnt != '0;
  assign credit_ok   = !rst && !flushing && (meta_count < CW'(FIFO_DEPTH));
  assign lk_req_valid = s_hdr_valid && credit_ok;
  assign lk_req_key  = s_hdr_key;
  assign s_hdr_ready = lk_req_ready && credit_ok;
  assign accept      = s_hdr_valid && s_hdr_ready;
  // A response with no unmatched metadata has nothing to join with and is dropped.
  assign resp_orphan = lk_resp_valid && !flushing && (result_count == meta_count);
  assign resp_push   = lk_resp_valid && !flushing && (result_count != meta_count);
  assign retire      = (meta_count != '0) && (result_count != '0) && (!m_pkt_valid || m_pkt_ready);
  assign head_hit    = res_mem[res_rd][RESP_WIDTH];
  always_ff @(posedge clk) begin
    if (accept) meta_mem[meta_wr] <= s_hdr_meta;
    if (resp_push) res_mem[res_wr] <= {lk_resp_hit, lk_resp_id};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt     <= LW'(LOOKUP_LATENCY);
      meta_wr       <= '0;
      meta_rd       <= '0;
      res_wr        <= '0;
      res_rd        <= '0;
      meta_count    <= '0;
      result_count  <= '0;
      m_pkt_valid   <= 1'b0;
      m_pkt_meta    <= '0;
      m_pkt_conn_id <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      resp_err      <= 1'b0;
    end else begin
      flush_cnt    <= flushing ? flush_cnt - 1'b1 : flush_cnt;
      meta_wr      <= accept ? meta_wr + 1'b1 : meta_wr;
      res_wr       <= resp_push ? res_wr + 1'b1 : res_wr;
      meta_rd      <= retire ? meta_rd + 1'b1 : meta_rd;
      res_rd       <= retire ? res_rd + 1'b1 : res_rd;
      meta_count   <= meta_count + CW'(accept) - CW'(retire);
      result_count <= result_count + CW'(resp_push) - CW'(retire);
      resp_err     <= resp_err || resp_orphan;
      if (retire && head_hit) begin
        m_pkt_valid   <= 1'b1;
        m_pkt_meta    <= meta_mem[meta_rd];
        m_pkt_conn_id <= res_mem[res_rd][RESP_WIDTH-1:0];
      end else if (m_pkt_ready) begin
        m_pkt_valid <= 1'b0;
      end
      hit_count  <= clear_counters ? '0 :
                    (retire && head_hit && !(&hit_count)) ? hit_count + 1'b1 : hit_count;
      miss_count <= clear_counters ? '0 :
                    (retire && !head_hit && !(&miss_count)) ? miss_count + 1'b1 : miss_count;
    end
  end
endmodule

// File: tb/tb_session_lookup_filter.sv
// tb_session_lookup_filter: scoreboard bench with a fixed-latency lookup responder model.
module tb_session_lookup_filter;
  localparam int KW = 32, RW = 18, MW = 64, D = 8, LL = 2, CW = 4;
  logic clk = 0, rst = 1;
  logic s_hdr_valid = 0, lk_req_ready = 0, m_pkt_ready = 0, clear_counters = 0;
  logic [KW-1:0] s_hdr_key = '0;
  logic [MW-1:0] s_hdr_meta = '0;
  logic s_hdr_ready, lk_req_valid, m_pkt_valid, resp_err;
  logic [KW-1:0] lk_req_key;
  logic lk_resp_valid, lk_resp_hit;
  logic [RW-1:0] lk_resp_id;
  logic [MW-1:0] m_pkt_meta;
  logic [RW-1:0] m_pkt_conn_id;
  logic [CW-1:0] hit_count, miss_count;
  logic rsp_v = 0, rsp_hit = 0, inj = 0;
  logic [RW-1:0] rsp_id = '0;
  int n_tests = 0, n_fail = 0, cyc = 0, n_acc = 0;
  typedef struct packed {logic [MW-1:0] meta; logic [RW-1:0] id;} pkt_t;
  typedef struct {int due; logic hit; logic [RW-1:0] id;} rsp_t;
  pkt_t exp_q[$], got_q[$];
  rsp_t rq[$];

  assign lk_resp_valid = rsp_v | inj;
  assign lk_resp_hit   = rsp_hit;
  assign lk_resp_id    = rsp_id;

  session_lookup_filter #(.KEY_WIDTH(KW), .RESP_WIDTH(RW), .META_WIDTH(MW), .FIFO_DEPTH(D),
    .LOOKUP_LATENCY(LL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .s_hdr_valid(s_hdr_valid), .s_hdr_key(s_hdr_key), .s_hdr_meta(s_hdr_meta),
    .s_hdr_ready(s_hdr_ready), .lk_req_valid(lk_req_valid), .lk_req_key(lk_req_key),
    .lk_req_ready(lk_req_ready), .lk_resp_valid(lk_resp_valid), .lk_resp_hit(lk_resp_hit),
    .lk_resp_id(lk_resp_id), .m_pkt_valid(m_pkt_valid), .m_pkt_meta(m_pkt_meta),
    .m_pkt_conn_id(m_pkt_conn_id), .m_pkt_ready(m_pkt_ready), .clear_counters(clear_counters),
    .hit_count(hit_count), .miss_count(miss_count), .resp_err(resp_err));

  always #5 clk = ~clk;

  // Lookup model: keys ending in 2'b10 miss, all others hit with an ID derived from the key.
  function automatic logic is_hit(input logic [KW-1:0] k);
    return k[1:0] != 2'b10;
  endfunction
  function automatic logic [RW-1:0] id_of(input logic [KW-1:0] k);
    return {1'b0, k[1], 11'h0, 1'b1, k[3:0]};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    rsp_v = 0;
    if (rq.size() != 0 && rq[0].due == cyc) begin
      rsp_v = 1; rsp_hit = rq[0].hit; rsp_id = rq[0].id;
      void'(rq.pop_front());
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && s_hdr_valid && s_hdr_ready) begin
      n_acc++;
      rq.push_back('{due: cyc + LL, hit: is_hit(s_hdr_key), id: id_of(s_hdr_key)});
      if (is_hit(s_hdr_key)) exp_q.push_back({s_hdr_meta, id_of(s_hdr_key)});
    end
    if (m_pkt_valid && m_pkt_ready) got_q.push_back({m_pkt_meta, m_pkt_conn_id});
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic hdr(input logic [KW-1:0] k, input logic [MW-1:0] m);
    s_hdr_valid = 1; s_hdr_key = k; s_hdr_meta = m;
  endtask

  task automatic test_reset();
    rst = 1; s_hdr_valid = 1; s_hdr_key = 32'h0A000001; lk_req_ready = 1; m_pkt_ready = 1;
    repeat (3) tick();
    @(negedge clk);
    n_tests++; if (s_hdr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_hdr_ready got=%0b exp=0", s_hdr_ready); end
    n_tests++; if (lk_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_lk_req_valid got=%0b exp=0", lk_req_valid); end
    n_tests++; if ({m_pkt_valid, m_pkt_meta, m_pkt_conn_id} !== '0) begin n_fail++; $display("FAIL rst_output got=%0h exp=0", {m_pkt_valid, m_pkt_meta, m_pkt_conn_id}); end
    n_tests++; if ({hit_count, miss_count, resp_err} !== '0) begin n_fail++; $display("FAIL rst_stats got=%0h exp=0", {hit_count, miss_count, resp_err}); end
    tick(); s_hdr_valid = 0; rst = 0;
    @(negedge clk);
    n_tests++; if (s_hdr_ready !== 1'b0) begin n_fail++; $display("FAIL flush_cycle1 got=%0b exp=0", s_hdr_ready); end
    tick(); @(negedge clk);
    n_tests++; if (s_hdr_ready !== 1'b0) begin n_fail++; $display("FAIL flush_cycle2 got=%0b exp=0", s_hdr_ready); end
    tick(); @(negedge clk);
    n_tests++; if (s_hdr_ready !== 1'b1) begin n_fail++; $display("FAIL flush_end got=%0b exp=1", s_hdr_ready); end
  endtask

  task automatic test_basic();
    int t_acc, first_v;
    tick(); clear_counters = 1; tick(); clear_counters = 0;
    hdr(32'h0A000001, 64'h1111_0000_0000_0001); t_acc = cyc;
    tick(); hdr(32'h0A000002, 64'h1111_0000_0000_0002);
    tick(); hdr(32'h0A000003, 64'h1111_0000_0000_0003);
    tick(); s_hdr_valid = 0;
    first_v = -1;
    for (int i = 0; i < 20; i++) begin
      if (m_pkt_valid && first_v < 0) first_v = cyc;
      tick();
    end
    n_tests++; if (first_v - t_acc !== 4) begin n_fail++; $display("FAIL basic_latency got=%0d exp=4", first_v - t_acc); end
    n_tests++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL basic_out_count got=%0d exp=2", got_q.size()); end
    if (got_q.size() == 2) begin
      n_tests++; if (got_q[0] !== {64'h1111_0000_0000_0001, 18'h00011}) begin n_fail++; $display("FAIL basic_pkt0 got=%0h exp=%0h", got_q[0], {64'h1111_0000_0000_0001, 18'h00011}); end
      n_tests++; if (got_q[1] !== {64'h1111_0000_0000_0003, 18'h10013}) begin n_fail++; $display("FAIL basic_pkt1 got=%0h exp=%0h", got_q[1], {64'h1111_0000_0000_0003, 18'h10013}); end
    end
    n_tests++; if (hit_count !== 4'd2) begin n_fail++; $display("FAIL basic_hit_count got=%0d exp=2", hit_count); end
    n_tests++; if (miss_count !== 4'd1) begin n_fail++; $display("FAIL basic_miss_count got=%0d exp=1", miss_count); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    for (int i = 0; i < 12; i++) begin
      hdr(32'h0C000001 + 32'(i << 2), 64'hC000 + 64'(i));
      if (!s_hdr_ready) stalls++;
      tick();
    end
    s_hdr_valid = 0;
    for (int i = 0; i < 50 && got_q.size() < 12; i++) tick();
    n_tests++; if (stalls !== 0) begin n_fail++; $display("FAIL b2b_stalls got=%0d exp=0", stalls); end
    n_tests++; if (got_q.size() !== 12) begin n_fail++; $display("FAIL b2b_out_count got=%0d exp=12", got_q.size()); end
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      n_tests++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL b2b_pkt got=%0h exp=%0h", got_q[0], exp_q[0]); end
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
    n_tests++; if (got_q.size() + exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_leftover got=%0d exp=0", got_q.size() + exp_q.size()); end
    n_tests++; if (hit_count !== 4'd14) begin n_fail++; $display("FAIL b2b_hit_count got=%0d exp=14", hit_count); end
  endtask

  task automatic test_stray();
    tick(); inj = 1; tick(); inj = 0;
    repeat (4) tick();
    @(negedge clk);
    n_tests++; if (resp_err !== 1'b1) begin n_fail++; $display("FAIL stray_err got=%0b exp=1", resp_err); end
    n_tests++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL stray_output got=%0d exp=0", got_q.size()); end
    n_tests++; if ({hit_count, miss_count} !== {4'd14, 4'd1}) begin n_fail++; $display("FAIL stray_counts got=%0h exp=e1", {hit_count, miss_count}); end
    tick(); clear_counters = 1; tick(); clear_counters = 0;
    repeat (3) tick();
    @(negedge clk);
    n_tests++; if (resp_err !== 1'b1) begin n_fail++; $display("FAIL stray_sticky got=%0b exp=1", resp_err); end
  endtask

  task automatic test_reset_midflight();
    int vcnt = 0;
    tick(); hdr(32'h0A000005, 64'hAAAA_0001);
    tick(); hdr(32'h0A000009, 64'hAAAA_0002);
    tick(); s_hdr_valid = 0; rst = 1;
    if (m_pkt_valid) vcnt++;
    tick(); rst = 0;
    @(negedge clk);
    n_tests++; if (s_hdr_ready !== 1'b0) begin n_fail++; $display("FAIL mid_flush1 got=%0b exp=0", s_hdr_ready); end
    n_tests++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL mid_err_cleared got=%0b exp=0", resp_err); end
    if (m_pkt_valid) vcnt++;
    tick(); @(negedge clk);
    n_tests++; if (s_hdr_ready !== 1'b0) begin n_fail++; $display("FAIL mid_flush2 got=%0b exp=0", s_hdr_ready); end
    if (m_pkt_valid) vcnt++;
    tick(); @(negedge clk);
    n_tests++; if (s_hdr_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got=%0b exp=1", s_hdr_ready); end
    for (int i = 0; i < 8; i++) begin
      if (m_pkt_valid) vcnt++;
      tick();
    end
    n_tests++; if (vcnt !== 0) begin n_fail++; $display("FAIL mid_no_output got=%0d exp=0", vcnt); end
    n_tests++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL mid_err got=%0b exp=0", resp_err); end
    n_tests++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL mid_got got=%0d exp=0", got_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    int idx = 0;
    logic acc;
    m_pkt_ready = 0;
    tick(); hdr(32'h0B0000F1, 64'hFEED);
    tick(); s_hdr_valid = 0;
    for (int i = 0; i < 10 && !m_pkt_valid; i++) tick();
    n_tests++; if (m_pkt_valid !== 1'b1) begin n_fail++; $display("FAIL bp_preload got=%0b exp=1", m_pkt_valid); end
    repeat (30) begin
      hdr(32'h0B000001 + 32'(idx << 2), 64'hB000 + 64'(idx));
      acc = s_hdr_ready;
      tick();
      if (acc) idx++;
    end
    n_tests++; if (idx !== D) begin n_fail++; $display("FAIL bp_accepted got=%0d exp=%0d", idx, D); end
    n_tests++; if (s_hdr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low got=%0b exp=0", s_hdr_ready); end
    n_tests++; if ({m_pkt_valid, m_pkt_meta} !== {1'b1, 64'hFEED}) begin n_fail++; $display("FAIL bp_hold got=%0h exp=1feed", {m_pkt_valid, m_pkt_meta}); end
    m_pkt_ready = 1;
    for (int i = 0; i < 200 && idx < 20; i++) begin
      hdr(32'h0B000001 + 32'(idx << 2), 64'hB000 + 64'(idx));
      acc = s_hdr_ready;
      tick();
      if (acc) idx++;
    end
    s_hdr_valid = 0;
    for (int i = 0; i < 100 && got_q.size() < 21; i++) tick();
    n_tests++; if (got_q.size() !== 21) begin n_fail++; $display("FAIL bp_out_count got=%0d exp=21", got_q.size()); end
    for (int k = 0; k < 20 && k + 1 < got_q.size(); k++) begin
      n_tests++; if (got_q[k+1].meta !== 64'hB000 + 64'(k)) begin n_fail++; $display("FAIL bp_order got=%0h exp=%0h", got_q[k+1].meta, 64'hB000 + 64'(k)); end
    end
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      n_tests++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL bp_pkt got=%0h exp=%0h", got_q[0], exp_q[0]); end
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
    n_tests++; if (got_q.size() + exp_q.size() !== 0) begin n_fail++; $display("FAIL bp_leftover got=%0d exp=0", got_q.size() + exp_q.size()); end
    n_tests++; if (hit_count !== 4'hF) begin n_fail++; $display("FAIL bp_hit_sat got=%0d exp=15", hit_count); end
  endtask

  task automatic test_req_stall();
    int acc0;
    tick(); lk_req_ready = 0; hdr(32'h0D000001, 64'hD00D);
    acc0 = n_acc;
    repeat (5) begin
      @(negedge clk);
      n_tests++; if ({s_hdr_ready, lk_req_valid} !== 2'b01) begin n_fail++; $display("FAIL stall_handshake got=%0b exp=01", {s_hdr_ready, lk_req_valid}); end
      n_tests++; if (lk_req_key !== 32'h0D000001) begin n_fail++; $display("FAIL stall_key got=%0h exp=d000001", lk_req_key); end
      tick();
    end
    n_tests++; if (n_acc !== acc0) begin n_fail++; $display("FAIL stall_accepts got=%0d exp=%0d", n_acc, acc0); end
    lk_req_ready = 1;
    tick(); s_hdr_valid = 0;
    for (int i = 0; i < 20 && got_q.size() < 1; i++) tick();
    repeat (3) tick();
    n_tests++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL stall_out_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() != 0) begin
      n_tests++; if (got_q[0] !== {64'hD00D, 18'h00011}) begin n_fail++; $display("FAIL stall_pkt got=%0h exp=%0h", got_q[0], {64'hD00D, 18'h00011}); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_counters();
    int idx = 0;
    logic acc;
    clear_counters = 1; tick(); clear_counters = 0;
    for (int i = 0; i < 60 && idx < 17; i++) begin
      hdr(32'h0E000002 + 32'(idx << 2), 64'hE000 + 64'(idx));
      acc = s_hdr_ready;
      tick();
      if (acc) idx++;
    end
    s_hdr_valid = 0;
    repeat (8) tick();
    n_tests++; if (miss_count !== 4'hF) begin n_fail++; $display("FAIL miss_sat got=%0d exp=15", miss_count); end
    n_tests++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL miss_output got=%0d exp=0", got_q.size()); end
    hdr(32'h0E100001, 64'hE1);
    tick(); s_hdr_valid = 0;
    repeat (6) tick();
    n_tests++; if (hit_count !== 4'd1) begin n_fail++; $display("FAIL hit_before_clear got=%0d exp=1", hit_count); end
    hdr(32'h0E100005, 64'hE2);
    tick(); s_hdr_valid = 0;
    tick();
    tick(); clear_counters = 1;
    tick(); clear_counters = 0;
    n_tests++; if ({m_pkt_valid, m_pkt_meta} !== {1'b1, 64'hE2}) begin n_fail++; $display("FAIL clear_retire_out got=%0h exp=1e2", {m_pkt_valid, m_pkt_meta}); end
    n_tests++; if ({hit_count, miss_count} !== 8'h00) begin n_fail++; $display("FAIL clear_wins got=%0h exp=0", {hit_count, miss_count}); end
    tick();
    n_tests++; if (hit_count !== 4'd0) begin n_fail++; $display("FAIL clear_after got=%0d exp=0", hit_count); end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stray();
    test_reset_midflight();
    test_backpressure();
    test_req_stall();
    test_counters();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=stuck exp=finish");
    $fatal(1, "timeout");
  end
endmodule
